vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Pixel-timing generator sitting directly upstream of every sprite/palette drawing stage in the Jet Fighter display path.
- Produces DrawX/DrawY scan coordinates, the active-high visible-area flag `blank`, and HS/VS sync for 640x480@60.
- All outputs are registered on vga_clk and mutually aligned, so a drawing stage can look up pixel (DrawX, DrawY) and gate colour with `blank` in the same cycle.
- Also emits frame/line strobes and a frame counter for game-logic sequencing.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, asserted level of hs/vs (0 = active-low)

Ports:
- vga_clk  input  1  pixel clock (25 MHz nominal)
- reset_n  input  1  asynchronous active-low reset
- hs  output  1  horizontal sync
- vs  output  1  vertical sync
- blank  output  1  1 = current pixel is visible; 0 = porch/sync
- DrawX  output  10  current horizontal count, 0..H_TOTAL-1
- DrawY  output  10  current vertical count, 0..V_TOTAL-1
- line_start  output  1  1-cycle pulse when DrawX==0
- frame_start  output  1  1-cycle pulse when DrawX==0 and DrawY==0
- frame_count  output  8  completed-frame counter, wraps 255->0

Behaviour:
- Interface: one clock, vga_clk. reset_n is asynchronous, active-low.
- Derived totals: H_TOTAL = sum of the four H params (800); V_TOTAL = sum of the four V params (525). Both must be <=1024; violation is an elaboration error.
- Reset (asynchronous, immediate on reset_n low, including mid-frame):
  - DrawX=H_TOTAL-1 (799), DrawY=V_TOTAL-1 (524)
  - hs=vs=~SYNC_ACTIVE, blank=0
  - line_start=0, frame_start=0, frame_count=0
- First rising edge after reset release moves to (0,0) with blank=1, line_start=1, frame_start=1. frame_count does not increment on this wrap; it stays 0.
- Horizontal counter: increments every cycle and wraps H_TOTAL-1 -> 0.
- Vertical counter: increments only on horizontal wrap, and wraps V_TOTAL-1 -> 0 when both counters wrap together.
- frame_count: +1 on every frame wrap except the first wrap after reset.
- Alignment: all outputs are registered from next-state counter values, giving zero relative skew. In any cycle, hs, vs, blank and the strobes describe exactly the (DrawX, DrawY) presented in that cycle.
- blank = 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
- hs = SYNC_ACTIVE iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (656..751).
- vs = SYNC_ACTIVE iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (490..491), for the full line including porches.
- Scan-region state (VIS, HFP, HSYNC, HBP) is derived from the counters; no separate FSM register that could desynchronise from them.
- No combinational path from any input to any output.

Decomposition:
- vga_timing_pkg holds:
  - default timing constants
  - derived H_TOTAL/V_TOTAL functions
  - typedef coord_t = logic [9:0]
- One sub-module, vga_mod_counter:
  - parameter MOD, 10-bit
  - inputs: inc enable; outputs: count value, registered wrap flag, next-value output
  - asynchronous active-low reset to MOD-1
  - instantiated twice; the vertical instance's inc is the horizontal instance's wrap.

Test Plan:
- Reset release: hold reset_n=0 for 5 cycles, then release. Required: during reset DrawX=799, DrawY=524, blank=0, hs=vs=1. First edge after release gives DrawX=0, DrawY=0, blank=1, frame_start=1, line_start=1, frame_count=0.
- Horizontal line: run one line from DrawY=0. Required: blank=1 for exactly 640 cycles (DrawX 0..639) and falls with DrawX=640. hs=0 for exactly 96 cycles starting at DrawX=656. line_start pulses every 800 cycles.
- Vertical frame: run a full frame. Required: blank=0 on all lines 480..524. vs=0 for exactly 1600 cycles, starting at (0,490) and ending after (799,491). frame_start pulses exactly 420000 cycles apart.
- Frame counter: run 257 frames after reset. Required: frame_count increments at each frame_start after the first, reaches 255, then wraps to 0.
- Mid-frame reset: assert reset_n=0 asynchronously at (300,200). Required: without waiting for a clock edge, outputs return to reset values (DrawX=799, DrawY=524, blank=0, hs=vs=1, frame_count=0). Resumes at (0,0) after release.
- Parameter variant: SYNC_ACTIVE=1 with H_VISIBLE=320/V_VISIBLE=240 and other params unchanged (H_TOTAL=480, V_TOTAL=285). Required: hs high at DrawX 336..431, vs high on lines 250..251, blank=1 only for DrawX<320 and DrawY<240.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults, the scan-coordinate type and helpers.
// Pure declarations: no latency, no backpressure.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  // Largest total the 10-bit coordinate can count through.
  localparam int unsigned COORD_MAX_TOTAL = 1024;

  function automatic int unsigned h_total(input int unsigned vis, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return vis + front + sync + back;
  endfunction

  function automatic int unsigned v_total(input int unsigned vis, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return vis + front + sync + back;
  endfunction

  // Half-open span test done in 32 bits so an upper bound of 1024 stays exact.
  function automatic logic in_span(input coord_t v, input int unsigned lo, input int unsigned hi);
    return (32'(v) >= lo) && (32'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_mod_counter.sv
// Modulo-MOD counter resetting to MOD-1; wrap is a registered terminal-count flag.
// count_nxt is combinational from registers only; no backpressure (inc is a plain enable).
module vga_mod_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned MOD = 800
) (
  input  logic   vga_clk,
  input  logic   reset_n,
  input  logic   inc,
  output coord_t count,
  output coord_t count_nxt,
  output logic   wrap
);

  localparam coord_t LAST = coord_t'(MOD - 1);

  if (MOD < 2 || MOD > COORD_MAX_TOTAL) begin : g_bad_mod
    $error("vga_mod_counter: MOD must be in 2..1024");
  end

  // wrap is high while count sits on its last value, so the next inc rolls to zero.
  always_comb begin
    count_nxt = count;
    if (inc) begin
      count_nxt = wrap ? '0 : count + 10'd1;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= LAST;
      wrap  <= 1'b1;
    end else begin
      count <= count_nxt;
      wrap  <= (count_nxt == LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA scan generator: DrawX/DrawY, blank, hs/vs, line/frame strobes, frame counter.
// Every output is a register fed from next-state counts (zero relative skew); no backpressure.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT     = H_FRONT_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BACK      = H_BACK_DEF,
  parameter int unsigned V_VISIBLE   = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT     = V_FRONT_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BACK      = V_BACK_DEF,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL   = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL   = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned HS_START  = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END    = HS_START + H_SYNC;
  localparam int unsigned VS_START  = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END    = VS_START + V_SYNC;

  if (H_TOTAL > COORD_MAX_TOTAL || V_TOTAL > COORD_MAX_TOTAL) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  coord_t x_nxt;
  coord_t y_nxt;
  logic   h_wrap;
  logic   v_wrap;
  logic   frame_wrap;
  logic   wrapped_once;

  vga_mod_counter #(.MOD(H_TOTAL)) u_h_cnt (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .inc       (1'b1),
    .count     (DrawX),
    .count_nxt (x_nxt),
    .wrap      (h_wrap)
  );

  vga_mod_counter #(.MOD(V_TOTAL)) u_v_cnt (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .inc       (h_wrap),
    .count     (DrawY),
    .count_nxt (y_nxt),
    .wrap      (v_wrap)
  );

  // Both counters on their last value means the coming edge starts a new frame.
  assign frame_wrap = h_wrap & v_wrap;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs           <= ~SYNC_ACTIVE;
      vs           <= ~SYNC_ACTIVE;
      blank        <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      frame_count  <= 8'd0;
      wrapped_once <= 1'b0;
    end else begin
      hs          <= in_span(x_nxt, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vs          <= in_span(y_nxt, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      blank       <= (32'(x_nxt) < H_VISIBLE) && (32'(y_nxt) < V_VISIBLE);
      line_start  <= (x_nxt == '0);
      frame_start <= (x_nxt == '0) && (y_nxt == '0);
      // The wrap out of the reset position is not a completed frame.
      if (frame_wrap) begin
        wrapped_once <= 1'b1;
        if (wrapped_once) begin
          frame_count <= frame_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: three generator instances (default, 320x240 active-high sync, tiny frame) checked every cycle
// against an arithmetic scan-position model, plus hand-computed literal expectations.
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 vga_clk = ~vga_clk;

  int checks = 0;
  int errors = 0;
  int k = 0;  // rising edges since reset release; 0 while in reset

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       blank;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  typedef struct {
    int   hv, hf, hsw, hb;
    int   vv, vf, vsw, vb;
    logic sa;
  } tim_t;

  tim_t p_def, p_var, p_tiny;
  obs_t o_def, o_var, o_tiny;

  vga_timing_gen u_def (
    .vga_clk(vga_clk), .reset_n(reset_n), .hs(o_def.hs), .vs(o_def.vs), .blank(o_def.blank),
    .DrawX(o_def.x), .DrawY(o_def.y), .line_start(o_def.ls), .frame_start(o_def.fs),
    .frame_count(o_def.fc)
  );

  vga_timing_gen #(.H_VISIBLE(320), .V_VISIBLE(240), .SYNC_ACTIVE(1'b1)) u_var (
    .vga_clk(vga_clk), .reset_n(reset_n), .hs(o_var.hs), .vs(o_var.vs), .blank(o_var.blank),
    .DrawX(o_var.x), .DrawY(o_var.y), .line_start(o_var.ls), .frame_start(o_var.fs),
    .frame_count(o_var.fc)
  );

  vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                   .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)) u_tiny (
    .vga_clk(vga_clk), .reset_n(reset_n), .hs(o_tiny.hs), .vs(o_tiny.vs), .blank(o_tiny.blank),
    .DrawX(o_tiny.x), .DrawY(o_tiny.y), .line_start(o_tiny.ls), .frame_start(o_tiny.fs),
    .frame_count(o_tiny.fc)
  );

  always @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) k <= 0;
    else          k <= k + 1;
  end

  // Scan position is simply (edges-1) taken modulo the frame size.
  function automatic obs_t model(input int kk, input tim_t p);
    obs_t o;
    int ht, vt, pos, x, y;
    ht = p.hv + p.hf + p.hsw + p.hb;
    vt = p.vv + p.vf + p.vsw + p.vb;
    if (kk == 0) begin
      o.x = 10'(ht - 1);  o.y = 10'(vt - 1);
      o.hs = ~p.sa;       o.vs = ~p.sa;      o.blank = 1'b0;
      o.ls = 1'b0;        o.fs = 1'b0;       o.fc = 8'd0;
      return o;
    end
    pos = (kk - 1) % (ht * vt);
    x = pos % ht;
    y = pos / ht;
    o.x     = 10'(x);
    o.y     = 10'(y);
    o.blank = (x < p.hv) && (y < p.vv);
    o.hs    = (x >= p.hv + p.hf && x < p.hv + p.hf + p.hsw) ? p.sa : ~p.sa;
    o.vs    = (y >= p.vv + p.vf && y < p.vv + p.vf + p.vsw) ? p.sa : ~p.sa;
    o.ls    = (x == 0);
    o.fs    = (x == 0) && (y == 0);
    o.fc    = 8'(((kk - 1) / (ht * vt)) % 256);
    return o;
  endfunction

  function automatic obs_t lit(input logic hs, input logic vs, input logic blank, input int x,
                               input int y, input logic ls, input logic fs, input int fc);
    obs_t o;
    o.hs = hs; o.vs = vs; o.blank = blank; o.x = 10'(x); o.y = 10'(y);
    o.ls = ls; o.fs = fs; o.fc = 8'(fc);
    return o;
  endfunction

  task automatic chk_obs(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got hs=%b vs=%b blank=%b x=%0d y=%0d ls=%b fs=%b fc=%0d expected hs=%b vs=%b blank=%b x=%0d y=%0d ls=%b fs=%b fc=%0d",
               name, k, got.hs, got.vs, got.blank, got.x, got.y, got.ls, got.fs, got.fc,
               exp.hs, exp.vs, exp.blank, exp.x, exp.y, exp.ls, exp.fs, exp.fc);
    end
  endtask

  task automatic wait_k(input int target);
    int guard;
    guard = 0;
    while (k != target && guard < 100000) begin
      @(negedge vga_clk);
      guard++;
    end
    if (k != target) begin
      checks++;
      errors++;
      $display("FAIL wait_k got k=%0d expected k=%0d", k, target);
    end
  endtask

  always @(negedge vga_clk) begin
    chk_obs("model_def", o_def, model(k, p_def));
    chk_obs("model_var", o_var, model(k, p_var));
    chk_obs("model_tiny", o_tiny, model(k, p_tiny));
  end

  initial begin
    p_def  = '{hv: 640, hf: 16, hsw: 96, hb: 48, vv: 480, vf: 10, vsw: 2, vb: 33, sa: 1'b0};
    p_var  = '{hv: 320, hf: 16, hsw: 96, hb: 48, vv: 240, vf: 10, vsw: 2, vb: 33, sa: 1'b1};
    p_tiny = '{hv: 8,   hf: 2,  hsw: 3,  hb: 2,  vv: 4,   vf: 1,  vsw: 2, vb: 2,  sa: 1'b0};

    #1 reset_n = 1'b0;
    repeat (5) @(negedge vga_clk);
    chk_obs("rst_def",  o_def,  lit(1, 1, 0, 799, 524, 0, 0, 0));
    chk_obs("rst_var",  o_var,  lit(0, 0, 0, 479, 284, 0, 0, 0));
    chk_obs("rst_tiny", o_tiny, lit(1, 1, 0, 14, 8, 0, 0, 0));
    #2 reset_n = 1'b1;

    wait_k(1);
    chk_obs("first_def",  o_def,  lit(1, 1, 1, 0, 0, 1, 1, 0));
    chk_obs("first_var",  o_var,  lit(0, 0, 1, 0, 0, 1, 1, 0));
    wait_k(75);
    chk_obs("tiny_pre_vs", o_tiny, lit(1, 1, 0, 14, 4, 0, 0, 0));
    wait_k(76);
    chk_obs("tiny_vs_on",  o_tiny, lit(1, 0, 0, 0, 5, 1, 0, 0));
    wait_k(106);
    chk_obs("tiny_vs_off", o_tiny, lit(1, 1, 0, 0, 7, 1, 0, 0));
    wait_k(136);
    chk_obs("tiny_frame2", o_tiny, lit(1, 1, 1, 0, 0, 1, 1, 1));
    wait_k(321);
    chk_obs("var_blank_off", o_var, lit(0, 0, 0, 320, 0, 0, 0, 0));
    wait_k(337);
    chk_obs("var_hs_on", o_var, lit(1, 0, 0, 336, 0, 0, 0, 0));
    wait_k(640);
    chk_obs("def_last_vis", o_def, lit(1, 1, 1, 639, 0, 0, 0, 0));
    wait_k(641);
    chk_obs("def_blank_off", o_def, lit(1, 1, 0, 640, 0, 0, 0, 0));
    wait_k(657);
    chk_obs("def_hs_on", o_def, lit(0, 1, 0, 656, 0, 0, 0, 0));
    wait_k(752);
    chk_obs("def_hs_last", o_def, lit(0, 1, 0, 751, 0, 0, 0, 0));
    wait_k(753);
    chk_obs("def_hs_off", o_def, lit(1, 1, 0, 752, 0, 0, 0, 0));
    wait_k(801);
    chk_obs("def_line1", o_def, lit(1, 1, 1, 0, 1, 1, 0, 0));

    wait_k(255 * 135 + 1);
    chk_obs("tiny_fc255", o_tiny, lit(1, 1, 1, 0, 0, 1, 1, 255));
    wait_k(256 * 135 + 1);
    chk_obs("tiny_fc_wrap", o_tiny, lit(1, 1, 1, 0, 0, 1, 1, 0));
    wait_k(256 * 135 + 3 * 15 + 5 + 1);
    chk_obs("tiny_mid", o_tiny, lit(1, 1, 1, 5, 3, 0, 0, 0));

    #2 reset_n = 1'b0;
    #1;
    chk_obs("async_def",  o_def,  lit(1, 1, 0, 799, 524, 0, 0, 0));
    chk_obs("async_var",  o_var,  lit(0, 0, 0, 479, 284, 0, 0, 0));
    chk_obs("async_tiny", o_tiny, lit(1, 1, 0, 14, 8, 0, 0, 0));
    repeat (3) @(negedge vga_clk);
    #2 reset_n = 1'b1;

    wait_k(1);
    chk_obs("resume_def",  o_def,  lit(1, 1, 1, 0, 0, 1, 1, 0));
    chk_obs("resume_tiny", o_tiny, lit(1, 1, 1, 0, 0, 1, 1, 0));
    wait_k(136);
    chk_obs("resume_tiny_fc", o_tiny, lit(1, 1, 1, 0, 0, 1, 1, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
